cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//   Shares one common data bus (CDB) between N_REQ execution-unit result producers (ALU, LSB, Branch).
//   Each producer gets a DEPTH-entry result FIFO. A round-robin arbiter pops one head per cycle and
//   drives the registered CDB broadcast, which the reservation stations and the ROB snoop for tag wakeup.
//   A per-producer full flag tells the reservation station feeding that unit to hold issue.
// PARAMETERS
//   N_REQ   3   number of producers; index 0=ALU, 1=LSB, 2=Branch
//   DEPTH   2   entries per producer FIFO; power of two, >=2
//   TAG_W   4   ROB tag width
//   DATA_W  32  result data width
// PORTS
//   clk          in   1             clock, rising edge
//   rst_n        in   1             asynchronous reset, active low
//   rdy          in   1             global ready; low = freeze all state
//   clear        in   1             synchronous flush (mispredict), active high
//   req_en_i     in   N_REQ         per-producer result valid, one pulse per result
//   req_tag_i    in   N_REQ*TAG_W   per-producer ROB tag, slice k = [k*TAG_W +: TAG_W]
//   req_data_i   in   N_REQ*DATA_W  per-producer result data, slice k = [k*DATA_W +: DATA_W]
//   req_full_o   out  N_REQ         FIFO k holds DEPTH entries (combinational from count)
//   cdb_en_o     out  1             CDB broadcast valid (registered)
//   cdb_tag_o    out  TAG_W         CDB tag
//   cdb_data_o   out  DATA_W        CDB data
//   cdb_src_o    out  2             index of the producer that won the current broadcast
//   ovf_o        out  1             sticky: a push arrived while the FIFO was full
//   idle_o       out  1             all FIFOs empty and cdb_en_o low
// BEHAVIOUR
//   Reset (rst_n=0, async): all FIFOs empty. Read/write pointers = 0. rr_ptr = 0.
//     cdb_en_o/tag/data/src = 0, ovf_o = 0.
//   rdy=0: no state changes. Outputs hold. req_en_i is ignored.
//   clear=1 with rdy=1: all FIFOs emptied, rr_ptr=0, cdb_en_o/tag/data/src=0, same-cycle pushes dropped.
//     ovf_o is kept.
//   Push: req_en_i[k] & !req_full_o[k] writes {tag,data} at the tail of FIFO k on the edge.
//     If req_full_o[k]=1, the entry is dropped and ovf_o is set, even if FIFO k pops in the same cycle.
//   Arbitration (each rdy & !clear cycle):
//     - Candidates are the non-empty FIFOs, by count before this edge.
//     - The winner is the first candidate at or after rr_ptr, searching upward mod N_REQ.
//     - The winner's head is popped and registered into cdb_* with cdb_en_o=1 and cdb_src_o=winner.
//     - rr_ptr <= (winner+1) mod N_REQ.
//     - With no candidate: cdb_en_o<=0, tag/data/src<=0, rr_ptr unchanged.
//   Same FIFO pushed and popped in one cycle: count unchanged, order preserved.
//   No bypass: latency req_en_i -> cdb_en_o is exactly 2 cycles when uncontended.
//   Pointers wrap mod DEPTH. count ranges 0..DEPTH (width clog2(DEPTH)+1).
//   Fairness: a non-empty FIFO is served within N_REQ consecutive rdy cycles.
//   FIFO order is strict per producer. Interleaving across producers is arbitration order.
//   Any broadcast lasts exactly one cycle (while rdy=1). Back-to-back broadcasts are allowed.
//   idle_o = (all counts==0) & !cdb_en_o.
// TESTING
//   1 Single push: req_en_i=3'b001, tag=5, data=32'h1234 at cycle 0 -> cdb_en_o=1, tag=5, data=1234,
//     src=0 at cycle 2 only.
//   2 Contention: all three push at cycle 0 with tags 1,2,3 -> broadcasts in cycles 2,3,4 with tags 1,2,3,
//     src 0,1,2. rr_ptr then =0.
//   3 Fill/full: LSB pushes tags 7,8 on consecutive cycles while ALU is saturated -> req_full_o[1]=1.
//     A third push sets ovf_o=1; the later broadcasts show 7 then 8 only.
//   4 Clear mid-stream: 4 entries queued, clear=1 -> next cycle cdb_en_o=0, all full=0, idle_o=1.
//     No stale tag is ever broadcast.
//   5 rdy=0 for 3 cycles with 2 entries queued and cdb_en_o=1 -> outputs frozen, no pops.
//     After rdy=1 the sequence resumes unchanged.
//   6 Async reset asserted mid-broadcast between edges -> cdb_en_o=0 and ovf_o=0 immediately.
//     Everything is empty after release.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-producer result FIFOs drained one head per cycle
// by a round-robin arbiter into a registered CDB broadcast.
module cdb_arbiter #(
  parameter int N_REQ  = 3,
  parameter int DEPTH  = 2,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rdy,
  input  logic                    clear,
  input  logic [N_REQ-1:0]        req_en_i,
  input  logic [N_REQ*TAG_W-1:0]  req_tag_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  output logic [N_REQ-1:0]        req_full_o,
  output logic                    cdb_en_o,
  output logic [TAG_W-1:0]        cdb_tag_o,
  output logic [DATA_W-1:0]       cdb_data_o,
  output logic [1:0]              cdb_src_o,
  output logic                    ovf_o,
  output logic                    idle_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = TAG_W + DATA_W;

  logic [ENT_W-1:0]  mem_q [N_REQ][DEPTH];
  logic [ENT_W-1:0]  mem_d [N_REQ][DEPTH];
  logic [PTR_W-1:0]  wr_q  [N_REQ];
  logic [PTR_W-1:0]  wr_d  [N_REQ];
  logic [PTR_W-1:0]  rd_q  [N_REQ];
  logic [PTR_W-1:0]  rd_d  [N_REQ];
  logic [CNT_W-1:0]  cnt_q [N_REQ];
  logic [CNT_W-1:0]  cnt_d [N_REQ];
  logic [1:0]        rr_q, rr_d;
  logic              cdb_en_q, cdb_en_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [1:0]        cdb_src_q, cdb_src_d;
  logic              ovf_q, ovf_d;

  logic [N_REQ-1:0]  empty, push, pop;
  logic              win_vld;
  logic [1:0]        win_idx;
  logic [ENT_W-1:0]  head;

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      req_full_o[k] = (cnt_q[k] == CNT_W'(DEPTH));
      empty[k]      = (cnt_q[k] == '0);
    end
  end

  // Round-robin search starting at rr_q, based on occupancy before this edge.
  always_comb begin
    int cand;
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(rr_q) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!win_vld && !empty[cand]) begin
        win_vld = 1'b1;
        win_idx = 2'(cand);
      end
    end
  end

  always_comb begin
    head = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pop[k]  = win_vld && (win_idx == 2'(k));
      push[k] = req_en_i[k] && !req_full_o[k];
      if (pop[k]) head = mem_q[k][rd_q[k]];
    end
  end

  always_comb begin
    mem_d      = mem_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    cdb_en_d   = cdb_en_q;
    cdb_tag_d  = cdb_tag_q;
    cdb_data_d = cdb_data_q;
    cdb_src_d  = cdb_src_q;
    ovf_d      = ovf_q;
    if (rdy) begin
      if (clear) begin
        for (int k = 0; k < N_REQ; k++) begin
          wr_d[k]  = '0;
          rd_d[k]  = '0;
          cnt_d[k] = '0;
        end
        rr_d       = '0;
        cdb_en_d   = 1'b0;
        cdb_tag_d  = '0;
        cdb_data_d = '0;
        cdb_src_d  = '0;
      end else begin
        for (int k = 0; k < N_REQ; k++) begin
          // A full FIFO drops the push even if it is popped this same cycle.
          if (req_en_i[k] && req_full_o[k]) ovf_d = 1'b1;
          if (push[k]) begin
            mem_d[k][wr_q[k]] = {req_tag_i[k*TAG_W +: TAG_W], req_data_i[k*DATA_W +: DATA_W]};
            wr_d[k]           = wr_q[k] + PTR_W'(1);
          end
          if (pop[k]) rd_d[k] = rd_q[k] + PTR_W'(1);
          cnt_d[k] = cnt_q[k] + CNT_W'(push[k]) - CNT_W'(pop[k]);
        end
        if (win_vld) begin
          cdb_en_d   = 1'b1;
          cdb_tag_d  = head[ENT_W-1 -: TAG_W];
          cdb_data_d = head[DATA_W-1:0];
          cdb_src_d  = win_idx;
          rr_d       = (int'(win_idx) == N_REQ - 1) ? 2'd0 : win_idx + 2'd1;
        end else begin
          cdb_en_d   = 1'b0;
          cdb_tag_d  = '0;
          cdb_data_d = '0;
          cdb_src_d  = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_REQ; k++) begin
        wr_q[k]  <= '0;
        rd_q[k]  <= '0;
        cnt_q[k] <= '0;
      end
      rr_q       <= '0;
      cdb_en_q   <= 1'b0;
      cdb_tag_q  <= '0;
      cdb_data_q <= '0;
      cdb_src_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      cdb_en_q   <= cdb_en_d;
      cdb_tag_q  <= cdb_tag_d;
      cdb_data_q <= cdb_data_d;
      cdb_src_q  <= cdb_src_d;
      ovf_q      <= ovf_d;
    end
  end

  // Entry storage carries no reset; occupancy is tracked by the counters alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign cdb_en_o   = cdb_en_q;
  assign cdb_tag_o  = cdb_tag_q;
  assign cdb_data_o = cdb_data_q;
  assign cdb_src_o  = cdb_src_q;
  assign ovf_o      = ovf_q;
  assign idle_o     = (&empty) && !cdb_en_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: vector table, directed corner sequences and random
// traffic checked against a queue-based reference model.
module tb_cdb_arbiter;
  localparam int N = 3;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        clear = 1'b0;
  logic [2:0]  req_en = '0;
  logic [11:0] req_tag = '0;
  logic [95:0] req_data = '0;
  logic [2:0]  req_full;
  logic        cdb_en;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [1:0]  cdb_src;
  logic        ovf, idle;

  cdb_arbiter #(.N_REQ(3), .DEPTH(2), .TAG_W(4), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear(clear),
    .req_en_i(req_en), .req_tag_i(req_tag), .req_data_i(req_data),
    .req_full_o(req_full), .cdb_en_o(cdb_en), .cdb_tag_o(cdb_tag),
    .cdb_data_o(cdb_data), .cdb_src_o(cdb_src), .ovf_o(ovf), .idle_o(idle)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one FIFO queue per producer plus the broadcast register.
  logic [35:0] mq [3][$];
  int          m_rr;
  logic        m_en;
  logic [3:0]  m_tag;
  logic [31:0] m_data;
  logic [1:0]  m_src;
  logic        m_ovf;

  logic        collect_lsb = 1'b0;
  logic [3:0]  lsb_seen [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) mq[k].delete();
    m_rr = 0; m_en = 0; m_tag = 0; m_data = 0; m_src = 0; m_ovf = 0;
  endtask

  task automatic model_step();
    int   win;
    bit   full_b [3];
    logic [35:0] h;
    if (!rdy) return;
    if (clear) begin
      for (int k = 0; k < N; k++) mq[k].delete();
      m_rr = 0; m_en = 0; m_tag = 0; m_data = 0; m_src = 0;
      return;
    end
    for (int k = 0; k < N; k++) full_b[k] = (mq[k].size() >= DEPTH);
    win = -1;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_rr + i) % N;
      if (win < 0 && mq[k].size() > 0) win = k;
    end
    if (win >= 0) begin
      h = mq[win].pop_front();
      m_en = 1; m_tag = h[35:32]; m_data = h[31:0]; m_src = 2'(win);
      m_rr = (win + 1) % N;
    end else begin
      m_en = 0; m_tag = 0; m_data = 0; m_src = 0;
    end
    for (int k = 0; k < N; k++)
      if (req_en[k]) begin
        if (full_b[k]) m_ovf = 1;
        else mq[k].push_back({req_tag[k*4 +: 4], req_data[k*32 +: 32]});
      end
  endtask

  task automatic check_all();
    bit all_empty;
    all_empty = 1;
    chk("cdb_en", 64'(cdb_en), 64'(m_en));
    chk("cdb_tag", 64'(cdb_tag), 64'(m_tag));
    chk("cdb_data", 64'(cdb_data), 64'(m_data));
    chk("cdb_src", 64'(cdb_src), 64'(m_src));
    chk("ovf", 64'(ovf), 64'(m_ovf));
    for (int k = 0; k < N; k++) begin
      chk("req_full", 64'(req_full[k]), 64'(mq[k].size() == DEPTH));
      if (mq[k].size() != 0) all_empty = 0;
    end
    chk("idle", 64'(idle), 64'(all_empty && !m_en));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    if (collect_lsb && cdb_en && cdb_src == 2'd1) lsb_seen.push_back(cdb_tag);
  endtask

  task automatic clr_in();
    req_en = '0; req_tag = '0; req_data = '0; clear = 1'b0; rdy = 1'b1;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    clr_in();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_cdb_en", 64'(cdb_en), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_full", 64'(req_full), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [2:0]  en;
    logic [11:0] tag;
    logic [95:0] data;
    logic        x_en;
    logic [3:0]  x_tag;
    logic [31:0] x_data;
    logic [1:0]  x_src;
    logic [2:0]  x_full;
    logic        x_idle;
  } vec_t;

  vec_t tbl [7];

  initial begin
    // Contention from rr=0, then a single uncontended ALU push.
    tbl[0] = '{3'b111, {4'd3, 4'd2, 4'd1}, {32'hD3, 32'hD2, 32'hD1}, 1'b0, 4'd0, 32'h0, 2'd0, 3'b000, 1'b0};
    tbl[1] = '{3'b000, 12'h0, 96'h0, 1'b1, 4'd1, 32'hD1, 2'd0, 3'b000, 1'b0};
    tbl[2] = '{3'b000, 12'h0, 96'h0, 1'b1, 4'd2, 32'hD2, 2'd1, 3'b000, 1'b0};
    tbl[3] = '{3'b000, 12'h0, 96'h0, 1'b1, 4'd3, 32'hD3, 2'd2, 3'b000, 1'b0};
    tbl[4] = '{3'b001, {8'h0, 4'd5}, {64'h0, 32'h1234}, 1'b0, 4'd0, 32'h0, 2'd0, 3'b000, 1'b0};
    tbl[5] = '{3'b000, 12'h0, 96'h0, 1'b1, 4'd5, 32'h1234, 2'd0, 3'b000, 1'b0};
    tbl[6] = '{3'b000, 12'h0, 96'h0, 1'b0, 4'd0, 32'h0, 2'd0, 3'b000, 1'b1};

    model_reset();
    reset_dut();

    for (int i = 0; i < 7; i++) begin
      req_en = tbl[i].en; req_tag = tbl[i].tag; req_data = tbl[i].data;
      tick();
      chk("tbl_en", 64'(cdb_en), 64'(tbl[i].x_en));
      chk("tbl_tag", 64'(cdb_tag), 64'(tbl[i].x_tag));
      chk("tbl_data", 64'(cdb_data), 64'(tbl[i].x_data));
      chk("tbl_src", 64'(cdb_src), 64'(tbl[i].x_src));
      chk("tbl_full", 64'(req_full), 64'(tbl[i].x_full));
      chk("tbl_idle", 64'(idle), 64'(tbl[i].x_idle));
    end
    clr_in();

    // Fill LSB while ALU keeps winning; third LSB push overflows.
    reset_dut();
    collect_lsb = 1'b1;
    req_en = 3'b011; req_tag = {4'd0, 4'd7, 4'd1}; req_data = {32'h0, 32'h77, 32'hA1};
    tick();
    req_en = 3'b011; req_tag = {4'd0, 4'd8, 4'd2}; req_data = {32'h0, 32'h88, 32'hA2};
    tick();
    chk("lsb_full", 64'(req_full[1]), 64'd1);
    req_en = 3'b010; req_tag = {4'd0, 4'd9, 4'd0}; req_data = {32'h0, 32'h99, 32'h0};
    tick();
    chk("ovf_set", 64'(ovf), 64'd1);
    clr_in();
    repeat (4) tick();
    collect_lsb = 1'b0;
    chk("lsb_count", 64'(lsb_seen.size()), 64'd2);
    if (lsb_seen.size() == 2) begin
      chk("lsb_first", 64'(lsb_seen[0]), 64'd7);
      chk("lsb_second", 64'(lsb_seen[1]), 64'd8);
    end

    // Clear with several entries queued.
    req_en = 3'b111; req_tag = {4'd3, 4'd2, 4'd1}; req_data = {32'hC3, 32'hC2, 32'hC1};
    tick();
    req_en = 3'b111; req_tag = {4'd6, 4'd5, 4'd4}; req_data = {32'hC6, 32'hC5, 32'hC4};
    tick();
    req_en = 3'b111; clear = 1'b1;
    tick();
    chk("clr_en", 64'(cdb_en), 64'd0);
    chk("clr_full", 64'(req_full), 64'd0);
    chk("clr_idle", 64'(idle), 64'd1);
    chk("clr_ovf_kept", 64'(ovf), 64'd1);
    clr_in();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("clr_no_stale", 64'(cdb_en), 64'd0);
    end

    // Freeze with rdy low while a broadcast is up and two entries wait.
    req_en = 3'b111; req_tag = {4'd3, 4'd2, 4'd1}; req_data = {32'hE3, 32'hE2, 32'hE1};
    tick();
    req_en = 3'b000;
    tick();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_en = 3'b111; req_tag = 12'hFFF; req_data = '1;
      tick();
      chk("frz_en", 64'(cdb_en), 64'd1);
      chk("frz_tag", 64'(cdb_tag), 64'd1);
    end
    clr_in();
    tick();
    chk("resume_tag", 64'(cdb_tag), 64'd2);
    tick();
    chk("resume_tag2", 64'(cdb_tag), 64'd3);
    tick();

    // Asynchronous reset between edges during a broadcast.
    req_en = 3'b001; req_tag = 12'h00A; req_data = {64'h0, 32'hBEEF};
    tick();
    clr_in();
    tick();
    chk("pre_rst_en", 64'(cdb_en), 64'd1);
    chk("pre_rst_ovf", 64'(ovf), 64'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_en", 64'(cdb_en), 64'd0);
    chk("arst_ovf", 64'(ovf), 64'd0);
    chk("arst_idle", 64'(idle), 64'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < N; k++) req_en[k] = ($urandom_range(0, 9) < 6);
      req_tag  = 12'($urandom);
      req_data = {$urandom, $urandom, $urandom};
      rdy      = ($urandom_range(0, 9) != 0);
      clear    = ($urandom_range(0, 39) == 0);
      tick();
    end
    clr_in();
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
